pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter RESET_VEC, default 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have parameter TRAP_VEC, default 32'h0000_0100, misaligned-target trap handler address.
REQ-003 SHALL have parameter COP_TIMEOUT, default 1024, maximum cycles spent waiting for the coprocessor.
REQ-004 SHALL have one clock and a synchronous, active-high reset: clk  in  1  rising-edge clock; rst  in  1  synchronous active-high reset.
REQ-005 SHALL have ports: pc_cur  in  32  current PC register value; imem_ready  in  1  fetch accepted this cycle; hazard_stall  in  1  decode load-use stall.
REQ-006 SHALL have ports: br_taken  in  1; br_target  in  32; jal_valid  in  1; jal_target  in  32; cop_issue  in  1  coprocessor op issued; cop_done  in  1  coprocessor completion pulse.
REQ-007 SHALL have ports: pc_next  out  32  PC register D input; pc_write_en  out  1  PC register enable; flush  out  1  kill IF/ID; cop_timeout  out  1  one-cycle timeout pulse; state  out  2  FSM state.

Function
REQ-008 SHALL implement FSM states BOOT(0), RUN(1), WAIT_COP(2), TRAP(3).
REQ-009 SHALL drive outputs combinationally from registered state and current inputs; PC updates at the next clk edge (one-cycle latency decision -> pc_cur).
REQ-010 BOOT SHALL last exactly one cycle: pc_next=RESET_VEC, pc_write_en=1, flush=1, then -> RUN.
REQ-011 RUN SHALL apply priority: trap condition > jal_valid > br_taken > cop_issue > stall > sequential.
REQ-012 Redirect (jal or branch) SHALL give pc_next=target, pc_write_en=1, flush=1 for that cycle only; stay RUN.
REQ-013 Stall (hazard_stall=1 or imem_ready=0, no redirect) SHALL give pc_write_en=0, flush=0.
REQ-014 Sequential SHALL give pc_next=pc_cur+4, pc_write_en=1, modulo 2^32 (32'hFFFF_FFFC -> 0).
REQ-015 cop_issue in RUN SHALL write pc_cur+4, clear timeout counter, -> WAIT_COP; cop_done ignored outside WAIT_COP.
REQ-016 WAIT_COP SHALL hold pc_write_en=0, flush=0; counter increments each cycle; redirect inputs ignored.
REQ-017 cop_done in WAIT_COP SHALL -> RUN next cycle; cop_done in the same cycle the counter reaches COP_TIMEOUT-1 SHALL count as done (no timeout).
REQ-018 Counter reaching COP_TIMEOUT-1 without cop_done SHALL pulse cop_timeout for one cycle and -> RUN.

Reset
REQ-019 While rst=1: state=BOOT, counter=0, pc_write_en=0, flush=0, cop_timeout=0, pc_next=RESET_VEC.
REQ-020 rst asserted in any state, including WAIT_COP or TRAP, SHALL abandon the operation; first cycle after rst deasserts is BOOT.

Configuration
REQ-021 Macro PC_SEQ_TRAP_EN SHALL, when defined, enable TRAP: redirect target with bits[1:0]!=0 in RUN -> no PC write that cycle, -> TRAP; TRAP cycle drives pc_next=TRAP_VEC, pc_write_en=1, flush=1, then -> RUN.
REQ-022 Without PC_SEQ_TRAP_EN, redirect targets SHALL have bits[1:0] forced to 0 and state 3 SHALL be unreachable.

Structure
REQ-023 Shared package pc_seq_pkg SHALL hold the state encoding constants and default RESET_VEC/TRAP_VEC values.
REQ-024 Timeout counter SHALL be sub-module pc_seq_timer (clear, enable, expired); all else in pc_sequencer.

Verification
REQ-025 Reset release, imem_ready=1 -> BOOT cycle pc_next=0, flush=1; then pc_next 4, 8, 12 on consecutive cycles.
REQ-026 pc_cur=0x10, br_taken=1, br_target=0x40 and jal_valid=1, jal_target=0x80 same cycle -> pc_next=0x80, flush=1 one cycle.
REQ-027 pc_cur=0x20, cop_issue=1; cop_done after 5 cycles -> pc_write_en=0 for those 5 WAIT_COP cycles, RUN resumes with pc_next=pc_cur+4.
REQ-028 COP_TIMEOUT=8, no cop_done -> cop_timeout pulses once on the 8th WAIT_COP cycle, then RUN.
REQ-029 With PC_SEQ_TRAP_EN, br_target=0x42 -> TRAP, pc_next=0x100; without macro -> pc_next=0x40.
REQ-030 pc_cur=32'hFFFF_FFFC sequential -> pc_next=0; rst mid-WAIT_COP -> BOOT, pc_next=RESET_VEC.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// Shared types and default vectors for the PC sequencer and its timeout timer.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    StBoot    = 2'd0,
    StRun     = 2'd1,
    StWaitCop = 2'd2,
    StTrap    = 2'd3
  } pc_state_e;

  localparam logic [31:0] DefResetVec = 32'h0000_0000;
  localparam logic [31:0] DefTrapVec  = 32'h0000_0100;

endpackage

// File: rtl/pc_seq_timer.sv
// Coprocessor wait counter: cleared on issue, counts while enabled and flags the last
// allowed cycle (count == Limit-1).
module pc_seq_timer #(
  parameter int unsigned Limit = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CntW = (Limit > 1) ? $clog2(Limit) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(Limit - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign expired = (cnt_q == LastCnt);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && !expired) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC decision FSM (BOOT/RUN/WAIT_COP/TRAP). Define PC_SEQ_TRAP_EN to trap on
// misaligned redirect targets; otherwise target bits [1:0] are cleared.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_VEC   = DefResetVec,
  parameter logic [31:0] TRAP_VEC    = DefTrapVec,
  parameter int unsigned COP_TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_cur,
  input  logic        imem_ready,
  input  logic        hazard_stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        jal_valid,
  input  logic [31:0] jal_target,
  input  logic        cop_issue,
  input  logic        cop_done,
  output logic [31:0] pc_next,
  output logic        pc_write_en,
  output logic        flush,
  output logic        cop_timeout,
  output logic [1:0]  state
);

  pc_state_e   state_q, state_d;
  logic        tmr_clear, tmr_enable, tmr_expired;
  logic        redirect, trap_hit, stall;
  logic [31:0] redir_target, target_eff, pc_seq;

  assign pc_seq       = pc_cur + 32'd4;
  assign redirect     = jal_valid | br_taken;
  assign redir_target = jal_valid ? jal_target : br_target;
  assign stall        = hazard_stall | ~imem_ready;
  assign tmr_enable   = (state_q == StWaitCop);

`ifdef PC_SEQ_TRAP_EN
  assign trap_hit   = redirect && (redir_target[1:0] != 2'b00);
  assign target_eff = redir_target;
`else
  assign trap_hit   = 1'b0;
  assign target_eff = redir_target & ~32'h3;
`endif

  always_comb begin
    state_d     = state_q;
    pc_next     = pc_cur;
    pc_write_en = 1'b0;
    flush       = 1'b0;
    cop_timeout = 1'b0;
    tmr_clear   = 1'b0;
    unique case (state_q)
      StBoot: begin
        pc_next     = RESET_VEC;
        pc_write_en = 1'b1;
        flush       = 1'b1;
        state_d     = StRun;
      end
      StRun: begin
        if (trap_hit) begin
          state_d = StTrap;
        end else if (redirect) begin
          pc_next     = target_eff;
          pc_write_en = 1'b1;
          flush       = 1'b1;
        end else if (cop_issue) begin
          pc_next     = pc_seq;
          pc_write_en = 1'b1;
          tmr_clear   = 1'b1;
          state_d     = StWaitCop;
        end else if (!stall) begin
          pc_next     = pc_seq;
          pc_write_en = 1'b1;
        end
      end
      StWaitCop: begin
        // A completion on the last allowed cycle wins over the timeout.
        if (cop_done) begin
          state_d = StRun;
        end else if (tmr_expired) begin
          cop_timeout = 1'b1;
          state_d     = StRun;
        end
      end
      StTrap: begin
        pc_next     = TRAP_VEC;
        pc_write_en = 1'b1;
        flush       = 1'b1;
        state_d     = StRun;
      end
      default: state_d = StBoot;
    endcase
    if (rst) begin
      state_d     = StBoot;
      pc_next     = RESET_VEC;
      pc_write_en = 1'b0;
      flush       = 1'b0;
      cop_timeout = 1'b0;
      tmr_clear   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StBoot;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = rst ? StBoot : state_q;

  pc_seq_timer #(
    .Limit(COP_TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (tmr_clear),
    .enable (tmr_enable),
    .expired(tmr_expired)
  );

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus random traffic against a
// cycle-level reference model of the sequencing rules.
module tb_pc_sequencer;

  localparam int unsigned CopTo   = 8;
  localparam logic [31:0] RstVec  = 32'h0000_0000;
  localparam logic [31:0] TrapVec = 32'h0000_0100;

  logic        clk, rst;
  logic [31:0] pc_cur, br_target, jal_target, pc_next;
  logic        imem_ready, hazard_stall, br_taken, jal_valid, cop_issue, cop_done;
  logic        pc_write_en, flush, cop_timeout;
  logic [1:0]  state;

  int n_checks = 0;
  int n_errors = 0;
  int m_mode   = 0;  // 0 boot, 1 run, 2 wait-cop, 3 trap
  int m_waited = 0;  // wait-cop cycles already spent

  pc_sequencer #(
    .COP_TIMEOUT(CopTo)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pc_cur      (pc_cur),
    .imem_ready  (imem_ready),
    .hazard_stall(hazard_stall),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .jal_valid   (jal_valid),
    .jal_target  (jal_target),
    .cop_issue   (cop_issue),
    .cop_done    (cop_done),
    .pc_next     (pc_next),
    .pc_write_en (pc_write_en),
    .flush       (flush),
    .cop_timeout (cop_timeout),
    .state       (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Predict this cycle's outputs, compare at the falling edge, advance the model at the
  // rising edge and load the bench PC register from the predicted write.
  task automatic tick(input string tag);
    logic [31:0] e_next, tgt;
    logic        e_we, e_fl, e_to;
    bit          redir, trap;
    int          n_mode;
    e_next = pc_cur;
    e_we   = 1'b0;
    e_fl   = 1'b0;
    e_to   = 1'b0;
    n_mode = m_mode;
    if (rst) begin
      e_next   = RstVec;
      n_mode   = 0;
      m_waited = 0;
    end else if (m_mode == 0) begin
      e_next = RstVec;
      e_we   = 1'b1;
      e_fl   = 1'b1;
      n_mode = 1;
    end else if (m_mode == 1) begin
      redir = jal_valid || br_taken;
      tgt   = jal_valid ? jal_target : br_target;
`ifdef PC_SEQ_TRAP_EN
      trap = redir && (tgt % 4 != 0);
`else
      trap = 1'b0;
      tgt  = tgt - (tgt % 4);
`endif
      if (trap) begin
        n_mode = 3;
      end else if (redir) begin
        e_next = tgt;
        e_we   = 1'b1;
        e_fl   = 1'b1;
      end else if (cop_issue) begin
        e_next   = pc_cur + 32'd4;
        e_we     = 1'b1;
        n_mode   = 2;
        m_waited = 0;
      end else if (!hazard_stall && imem_ready) begin
        e_next = pc_cur + 32'd4;
        e_we   = 1'b1;
      end
    end else if (m_mode == 2) begin
      m_waited++;
      if (cop_done) begin
        n_mode = 1;
      end else if (m_waited == CopTo) begin
        e_to   = 1'b1;
        n_mode = 1;
      end
    end else begin
      e_next = TrapVec;
      e_we   = 1'b1;
      e_fl   = 1'b1;
      n_mode = 1;
    end
    @(negedge clk);
    check_eq({tag, ".state"}, 32'(state), rst ? 32'd0 : 32'(m_mode));
    check_eq({tag, ".we"}, 32'(pc_write_en), 32'(e_we));
    check_eq({tag, ".flush"}, 32'(flush), 32'(e_fl));
    check_eq({tag, ".timeout"}, 32'(cop_timeout), 32'(e_to));
    if (e_we || rst) check_eq({tag, ".pc_next"}, pc_next, e_next);
    @(posedge clk);
    m_mode = n_mode;
    #1;
    if (e_we) pc_cur = e_next;
  endtask

  task automatic idle_inputs();
    rst          = 1'b0;
    imem_ready   = 1'b1;
    hazard_stall = 1'b0;
    br_taken     = 1'b0;
    br_target    = '0;
    jal_valid    = 1'b0;
    jal_target   = '0;
    cop_issue    = 1'b0;
    cop_done     = 1'b0;
  endtask

  function automatic logic [31:0] rand_tgt();
    logic [31:0] t;
    t = $urandom;
    if ($urandom_range(0, 2) != 0) t[1:0] = 2'b00;
    return t;
  endfunction

  initial begin
    idle_inputs();
    pc_cur = '0;
    rst    = 1'b1;
    tick("reset0");
    tick("reset1");
    rst = 1'b0;
    tick("boot");
    for (int i = 0; i < 3; i++) tick("seq");
    check_eq("seq_pc_after3", pc_cur, 32'd12);

    pc_cur     = 32'h10;
    br_taken   = 1'b1;
    br_target  = 32'h40;
    jal_valid  = 1'b1;
    jal_target = 32'h80;
    tick("jal_over_br");
    idle_inputs();
    check_eq("jal_pc", pc_cur, 32'h80);
    tick("after_jal");

    pc_cur    = 32'h20;
    cop_issue = 1'b1;
    tick("cop_issue");
    cop_issue = 1'b0;
    for (int i = 0; i < 4; i++) tick("cop_wait");
    cop_done = 1'b1;
    tick("cop_done");
    cop_done = 1'b0;
    tick("cop_resume");
    check_eq("cop_resume_pc", pc_cur, 32'h28);

    cop_issue = 1'b1;
    tick("to_issue");
    cop_issue = 1'b0;
    for (int i = 0; i < int'(CopTo); i++) tick("to_wait");
    tick("to_resume");

    cop_issue = 1'b1;
    tick("edge_issue");
    cop_issue = 1'b0;
    for (int i = 0; i < int'(CopTo) - 1; i++) tick("edge_wait");
    cop_done = 1'b1;
    tick("edge_done");
    cop_done = 1'b0;
    tick("edge_resume");

    br_taken  = 1'b1;
    br_target = 32'h42;
    tick("misaligned_br");
    idle_inputs();
    tick("after_misaligned");

    pc_cur = 32'hFFFF_FFFC;
    tick("wrap");
    check_eq("wrap_pc", pc_cur, 32'h0);

    cop_issue = 1'b1;
    tick("rst_issue");
    cop_issue = 1'b0;
    for (int i = 0; i < 3; i++) tick("rst_wait");
    rst = 1'b1;
    tick("rst_mid_wait");
    rst = 1'b0;
    tick("rst_boot");
    tick("rst_run");

    for (int i = 0; i < 1500; i++) begin
      rst          = ($urandom_range(0, 63) == 0);
      jal_valid    = ($urandom_range(0, 9) == 0);
      jal_target   = rand_tgt();
      br_taken     = ($urandom_range(0, 5) == 0);
      br_target    = rand_tgt();
      cop_issue    = ($urandom_range(0, 9) == 0);
      cop_done     = ($urandom_range(0, 5) == 0);
      hazard_stall = ($urandom_range(0, 4) == 0);
      imem_ready   = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 15) == 0) pc_cur = $urandom;
      if ($urandom_range(0, 63) == 0) pc_cur = 32'hFFFF_FFFC;
      tick("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
